// File: rtl/param_pipe_divider.sv
// Pipelined restoring divider: QUOT_W stages, one quotient bit per stage, QUOT_W en-qualified cycles of latency.
// Define PIPE_DIV_REMAINDER_EN to register and drive the remainder; otherwise rem is tied to 0.
module param_pipe_divider #(
  parameter int QUOT_W     = 8,
  parameter int DIVISOR_W  = 20,
  parameter int DIVIDEND_W = DIVISOR_W + QUOT_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] divided,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     q,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  StartOut,
  output logic                  div_by_0,
  output logic                  ovf
);

  localparam int NR = QUOT_W - 1;

  logic                  w_in_vld  [QUOT_W];
  logic [DIVIDEND_W-1:0] w_in_prem [QUOT_W];
  logic [DIVISOR_W-1:0]  w_in_dvs  [QUOT_W];
  logic [QUOT_W-1:0]     w_in_q    [QUOT_W];
  logic                  w_in_dz   [QUOT_W];
  logic                  w_in_ovf  [QUOT_W];
  logic [DIVIDEND_W-1:0] w_out_prem[QUOT_W];
  logic [QUOT_W-1:0]     w_out_q   [QUOT_W];

  logic                  r_vld [NR];
  logic [DIVIDEND_W-1:0] r_prem[NR];
  logic [DIVISOR_W-1:0]  r_dvs [NR];
  logic [QUOT_W-1:0]     r_q   [NR];
  logic                  r_dz  [NR];
  logic                  r_ovf [NR];

  // Flags are resolved once on the raw operands and then ride along with them.
  assign w_in_vld[0]  = start;
  assign w_in_prem[0] = divided;
  assign w_in_dvs[0]  = divisor;
  assign w_in_q[0]    = '0;
  assign w_in_dz[0]   = (divisor == '0);
  assign w_in_ovf[0]  = (divisor != '0) && (divided[DIVIDEND_W-1:QUOT_W] >= divisor);

  for (genvar gi = 1; gi < QUOT_W; gi++) begin : g_link
    assign w_in_vld[gi]  = r_vld[gi-1];
    assign w_in_prem[gi] = r_prem[gi-1];
    assign w_in_dvs[gi]  = r_dvs[gi-1];
    assign w_in_q[gi]    = r_q[gi-1];
    assign w_in_dz[gi]   = r_dz[gi-1];
    assign w_in_ovf[gi]  = r_ovf[gi-1];
  end

  for (genvar gi = 0; gi < QUOT_W; gi++) begin : g_stage
    localparam int SH = QUOT_W - 1 - gi;
    logic [DIVIDEND_W:0] w_trial;
    logic                w_bit;
    // The extra MSB is the borrow: set means the shifted divisor did not fit.
    assign w_trial        = {1'b0, w_in_prem[gi]} - ((DIVIDEND_W+1)'(w_in_dvs[gi]) << SH);
    assign w_bit          = ~w_trial[DIVIDEND_W];
    assign w_out_prem[gi] = w_bit ? w_trial[DIVIDEND_W-1:0] : w_in_prem[gi];
    assign w_out_q[gi]    = w_in_q[gi] | (QUOT_W'(w_bit) << SH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NR; s++) r_vld[s] <= 1'b0;
    end else if (en) begin
      for (int s = 0; s < NR; s++) r_vld[s] <= w_in_vld[s];
    end
  end

  always_ff @(posedge clock) begin
    if (en) begin
      for (int s = 0; s < NR; s++) begin
        r_prem[s] <= w_out_prem[s];
        r_dvs[s]  <= w_in_dvs[s];
        r_q[s]    <= w_out_q[s];
        r_dz[s]   <= w_in_dz[s];
        r_ovf[s]  <= w_in_ovf[s];
      end
    end
  end

  logic w_last_vld;
  logic w_last_flag;
  assign w_last_vld  = w_in_vld[QUOT_W-1];
  assign w_last_flag = w_in_dz[QUOT_W-1] | w_in_ovf[QUOT_W-1];

  // The last stage writes straight into the output registers, so no extra cycle is added.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      StartOut <= 1'b0;
      q        <= '0;
      div_by_0 <= 1'b0;
      ovf      <= 1'b0;
    end else if (en) begin
      StartOut <= w_last_vld;
      if (w_last_vld) begin
        q        <= w_last_flag ? '1 : w_out_q[QUOT_W-1];
        div_by_0 <= w_in_dz[QUOT_W-1];
        ovf      <= w_in_ovf[QUOT_W-1];
      end
    end
  end

`ifdef PIPE_DIV_REMAINDER_EN
  logic [DIVISOR_W-1:0] r_rem;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rem <= '0;
    end else if (en && w_last_vld) begin
      r_rem <= w_last_flag ? '0 : w_out_prem[QUOT_W-1][DIVISOR_W-1:0];
    end
  end
  assign rem = r_rem;
`else
  assign rem = '0;
`endif

endmodule

// File: tb/tb_param_pipe_divider.sv
// Scoreboard bench for param_pipe_divider: expected results queued at issue, compared when StartOut fires.
module tb_param_pipe_divider;
  localparam int QW = 8;
  localparam int VW = 20;
  localparam int DW = 28;
`ifdef PIPE_DIV_REMAINDER_EN
  localparam bit REM_ON = 1'b1;
`else
  localparam bit REM_ON = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic          en;
  logic          start;
  logic [DW-1:0] divided;
  logic [VW-1:0] divisor;
  logic [QW-1:0] q;
  logic [VW-1:0] rem;
  logic          StartOut;
  logic          div_by_0;
  logic          ovf;

  param_pipe_divider #(.QUOT_W(QW), .DIVISOR_W(VW), .DIVIDEND_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .start(start),
    .divided(divided), .divisor(divisor),
    .q(q), .rem(rem), .StartOut(StartOut), .div_by_0(div_by_0), .ovf(ovf)
  );

  typedef struct {
    int            due;
    logic [QW-1:0] q;
    logic [VW-1:0] rem;
    logic          dz;
    logic          ov;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            en_cnt   = 0;
  bit            edge_en  = 1'b0;
  bit            exp_so;
  logic [QW-1:0] last_q   = '0;
  logic [VW-1:0] last_rem = '0;
  logic          last_so  = 1'b0;
  logic          last_dz  = 1'b0;
  logic          last_ov  = 1'b0;
  logic [DW-1:0] ra;
  logic [VW-1:0] rb;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] rx(input logic [VW-1:0] r);
    return r & {VW{REM_ON}};
  endfunction

  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    e.due = 0;
    if (b == '0) begin
      e.q = '1; e.rem = '0; e.dz = 1'b1; e.ov = 1'b0;
    end else if ((a >> QW) >= DW'(b)) begin
      e.q = '1; e.rem = '0; e.dz = 1'b0; e.ov = 1'b1;
    end else begin
      e.q = QW'(a / DW'(b)); e.rem = rx(VW'(a % DW'(b))); e.dz = 1'b0; e.ov = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clock) begin
    edge_en = reset_n && en;
    if (edge_en) en_cnt++;
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (edge_en) begin
        while (sb.size() > 0 && sb[0].due < en_cnt) begin
          check("lost_result", sb[0].due, en_cnt);
          void'(sb.pop_front());
        end
        exp_so = (sb.size() > 0) && (sb[0].due == en_cnt);
        check("startout", StartOut, exp_so);
        if (StartOut && exp_so) begin
          mon_e = sb.pop_front();
          check("q", q, mon_e.q);
          check("rem", rem, mon_e.rem);
          check("div_by_0", div_by_0, mon_e.dz);
          check("ovf", ovf, mon_e.ov);
        end else begin
          check("q_hold", q, last_q);
        end
      end else begin
        check("stall_startout", StartOut, last_so);
        check("stall_q", q, last_q);
        check("stall_rem", rem, last_rem);
      end
      last_q = q; last_rem = rem; last_so = StartOut; last_dz = div_by_0; last_ov = ovf;
    end
  end

  task automatic drive(input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b, input exp_t e);
    exp_t t;
    t = e;
    start = s; divided = a; divisor = b;
    if (s && en) begin
      t.due = en_cnt + QW;
      sb.push_back(t);
    end
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b,
                      input logic [QW-1:0] eq, input logic [VW-1:0] er, input logic edz, input logic eov);
    exp_t e;
    e.due = 0; e.q = eq; e.rem = rx(er); e.dz = edz; e.ov = eov;
    drive(1'b1, a, b, e);
  endtask

  task automatic send_m(input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b);
    drive(s, a, b, model(a, b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_m(1'b0, '0, '0);
  endtask

  task automatic stall(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) send_m(1'b1, DW'(28'h0ABCDEF), VW'(20'h00005));
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; en = 1'b0; start = 1'b0; divided = '0; divisor = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_startout", StartOut, 0);
    check("rst_q", q, 0);
    check("rst_rem", rem, 0);
    check("rst_div_by_0", div_by_0, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    en = 1'b1;

    // back-to-back, starting on the first edge after reset release
    send(765, 63, 12, 9, 0, 0);
    send(3315, 63, 52, 39, 0, 0);
    send(5865, 63, 93, 6, 0, 0);
    send(9180, 63, 145, 45, 0, 0);
    idle(QW + 2);

    // divide by zero and overflow boundary
    send(765, 0, 255, 0, 1, 0);
    send(16128, 63, 255, 0, 0, 1);
    send(16127, 63, 255, 62, 0, 0);
    send(28'hFFFFFFF, 20'hFFFFF, 255, 0, 0, 1);
    send(28'h00FFFFF, 20'h00001, 255, 0, 0, 1);
    send(28'h00000FF, 20'h00001, 255, 0, 0, 0);
    idle(QW + 2);

    // stall mid-stream while operands are in flight
    send(765, 63, 12, 9, 0, 0);
    send(3315, 63, 52, 39, 0, 0);
    stall(3);
    send(5865, 63, 93, 6, 0, 0);
    send(9180, 63, 145, 45, 0, 0);
    idle(QW - 3);
    stall(2);
    idle(QW);

    // bubble between two operations
    send(765, 63, 12, 9, 0, 0);
    idle(1);
    send(3315, 63, 52, 39, 0, 0);
    idle(QW + 2);

    // reset pulse while an operation is in flight
    send(9180, 63, 145, 45, 0, 0);
    idle(3);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_startout", StartOut, 0);
    check("midrst_q", q, 0);
    check("midrst_rem", rem, 0);
    check("midrst_div_by_0", div_by_0, 0);
    check("midrst_ovf", ovf, 0);
    last_q = '0; last_rem = '0; last_so = 1'b0; last_dz = 1'b0; last_ov = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    idle(QW + 3);

    // random traffic with random en stalls and bubbles
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rb = '0;
      else if (i % 2 == 0) rb = VW'($urandom_range(1, 300));
      else rb = VW'($urandom_range(1, 20'hFFFFF));
      ra = DW'($urandom) >> $urandom_range(0, 12);
      send_m($urandom_range(0, 3) != 0, ra, rb);
    end

    en = 1'b1; start = 1'b0;
    for (int i = 0; i < 3 * QW && sb.size() > 0; i++) begin
      @(posedge clock); #1;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
